dag_seq: RTL and testbench
==========================

Name: dag_seq

Overview:
- Sequencer/arbiter in front of the data address generator (DAG).
- The DAG produces one address per cycle: either DAG1 (DM side, dgsclt=0, registers I0-I7/M0-M7) or DAG2 (PM side, dgsclt=1, I8-I15/M8-M15).
- dag_seq arbitrates DM and PM address requests from decode, runs multi-beat post-modify bursts, and gates register writes that conflict with an active burst.
- All DAG control inputs (en, dgsclt, mdfy, iadd, madd, wrt_en, wrt_add) come from this block.

Parameters:
- LEN_W, 8, width of burst-length fields.
- RR_EN, 1, 1 = round-robin DM/PM arbitration; 0 = fixed DM priority.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- dm_req  in  1  DM address request; held until dm_gnt.
- dm_iadd  in  3  DAG1 I index.
- dm_madd  in  3  DAG1 M index.
- dm_mdfy  in  1  1 = pre-modify (I+M, no update); 0 = post-modify (I, then I+=M).
- dm_len  in  LEN_W  beat count; 0 is treated as 1.
- dm_gnt  out  1  one-cycle pulse: request accepted.
- dm_done  out  1  one-cycle pulse on the last beat.
- pm_req, pm_iadd, pm_madd, pm_mdfy, pm_len, pm_gnt, pm_done: same as the DM set, for DAG2.
- wr_req  in  1  register write request from the bus.
- wr_add  in  5  bit4 = 1 selects I, 0 selects M; bits 3:0 = register index.
- wr_rdy  out  1  write accepted this cycle.
- abort  in  1  terminate the active burst.
- ps_dg_en  out  1  DAG enable.
- ps_dg_dgsclt  out  1  0 = DAG1, 1 = DAG2.
- ps_dg_mdfy  out  1  pre/post-modify select.
- ps_dg_iadd  out  3  I index to the DAG.
- ps_dg_madd  out  3  M index to the DAG.
- ps_dg_wrt_en  out  1  write enable to the DAG.
- ps_dg_wrt_add  out  5  write address to the DAG.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset: all registered outputs 0; FSM = IDLE; beat counter = 0; last_grant = PM, so DM wins the first tie.
- FSM states:
  - IDLE, DM_BURST, PM_BURST.
  - IDLE: no requests → stay. One request → grant it. Both requests → RR_EN=1 grants the side opposite last_grant; RR_EN=0 grants DM.
  - On grant: capture iadd/madd/mdfy, set cnt = max(len,1); force cnt = 1 if mdfy=1 (pre-modify is always single-beat); pulse *_gnt; update last_grant; enter *_BURST.
- Latency:
  - Request seen in IDLE at edge t → gnt and first ps_dg_en at cycle t+1.
  - ps_dg_en stays high for exactly cnt consecutive cycles.
- In *_BURST:
  - Drive ps_dg_en=1 with the captured iadd/madd/mdfy; dgsclt=0 for DM, 1 for PM; decrement cnt each cycle.
  - On the cycle with cnt==1, pulse *_done and return to IDLE.
  - At least one idle cycle (ps_dg_en=0) separates consecutive bursts.
- ps_dg_en=0 in IDLE; iadd/madd/mdfy/dgsclt hold their last values.
- Requests arriving during a burst are not granted until IDLE; *_req must be held.
- abort:
  - In a burst: next cycle ps_dg_en=0, FSM → IDLE, no *_done.
  - In IDLE: ignored.
  - abort in the same cycle as a grant: the grant is completed and the new burst is aborted one cycle later.
- Write gating:
  - During a burst, conflict = (wr_add == {1, dgsclt, iadd}) OR (wr_add == {0, dgsclt, madd}), using the captured burst values.
  - wr_rdy = ~conflict (always 1 in IDLE).
  - ps_dg_wrt_en = wr_req & wr_rdy; ps_dg_wrt_add = wr_add (combinational pass-through).
  - A stalled write is released on the cycle after the last beat.
  - Non-conflicting writes proceed in parallel with a burst.
- Counter: LEN_W bits; len = 2^LEN_W-1 gives 255 beats (LEN_W=8); no wrap.
- Reset asserted mid-burst: everything clears immediately; no done pulse.

Test Plan:
- Single DM burst: dm_req, iadd=2, madd=1, mdfy=0, len=3 → dm_gnt at t+1; ps_dg_en high 3 cycles with dgsclt=0, iadd=2, madd=1; dm_done on the 3rd beat; busy falls after.
- Simultaneous requests, RR_EN=1: dm_req and pm_req both held (len=1) → order DM, PM, DM, PM, each burst separated by one idle cycle.
- Pre-modify single beat: pm_req, mdfy=1, len=5 → exactly 1 beat with dgsclt=1, mdfy=1; pm_done on that beat.
- Write conflict: DM burst iadd=4 len=4, wr_add=5'b10100 → wr_rdy=0 for all 4 beats, ps_dg_wrt_en pulses the following cycle. wr_add=5'b11000 during the burst → accepted immediately.
- abort on beat 2 of a len=6 burst → ps_dg_en low next cycle, no dm_done, FSM IDLE.
- rst_n low on beat 3 → all outputs 0 asynchronously; after release, first tie grants DM.

Source files
------------

// File: rtl/dag_seq_if.sv
// Request, arbitration and DAG-control bundle between decode/bus and dag_seq.
interface dag_seq_if #(
    parameter int unsigned LEN_W = 8
);
    logic             dm_req;
    logic [2:0]       dm_iadd;
    logic [2:0]       dm_madd;
    logic             dm_mdfy;
    logic [LEN_W-1:0] dm_len;
    logic             dm_gnt;
    logic             dm_done;

    logic             pm_req;
    logic [2:0]       pm_iadd;
    logic [2:0]       pm_madd;
    logic             pm_mdfy;
    logic [LEN_W-1:0] pm_len;
    logic             pm_gnt;
    logic             pm_done;

    logic             wr_req;
    logic [4:0]       wr_add;
    logic             wr_rdy;
    logic             abort;

    logic             ps_dg_en;
    logic             ps_dg_dgsclt;
    logic             ps_dg_mdfy;
    logic [2:0]       ps_dg_iadd;
    logic [2:0]       ps_dg_madd;
    logic             ps_dg_wrt_en;
    logic [4:0]       ps_dg_wrt_add;
    logic             busy;

    modport master (
        output dm_req, dm_iadd, dm_madd, dm_mdfy, dm_len,
        output pm_req, pm_iadd, pm_madd, pm_mdfy, pm_len,
        output wr_req, wr_add, abort,
        input  dm_gnt, dm_done, pm_gnt, pm_done, wr_rdy,
        input  ps_dg_en, ps_dg_dgsclt, ps_dg_mdfy, ps_dg_iadd, ps_dg_madd,
        input  ps_dg_wrt_en, ps_dg_wrt_add, busy
    );

    modport slave (
        input  dm_req, dm_iadd, dm_madd, dm_mdfy, dm_len,
        input  pm_req, pm_iadd, pm_madd, pm_mdfy, pm_len,
        input  wr_req, wr_add, abort,
        output dm_gnt, dm_done, pm_gnt, pm_done, wr_rdy,
        output ps_dg_en, ps_dg_dgsclt, ps_dg_mdfy, ps_dg_iadd, ps_dg_madd,
        output ps_dg_wrt_en, ps_dg_wrt_add, busy
    );
endinterface

// File: rtl/dag_seq.sv
// DAG sequencer: arbitrates DM/PM address requests, runs post-modify bursts
// and stalls register writes that target the active burst's I/M registers.
module dag_seq #(
    parameter int unsigned LEN_W = 8,
    parameter bit          RR_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    dag_seq_if.slave   bus
);
    localparam int unsigned IDX_W = 3;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DM_BURST = 2'd1,
        PM_BURST = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               grant_dm, grant_pm;
    logic               in_burst, last_beat, conflict;

    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   iadd_q, iadd_d;
    logic [IDX_W-1:0]   madd_q, madd_d;
    logic               mdfy_q, mdfy_d;
    logic               sel_q, sel_d;
    logic               last_q, last_d;
    logic               dm_gnt_q, dm_gnt_d, pm_gnt_q, pm_gnt_d;
    logic               dm_done_q, dm_done_d, pm_done_q, pm_done_d;

    // Pre-modify is always a single access; a zero length still issues one beat.
    function automatic logic [LEN_W-1:0] beats(input logic [LEN_W-1:0] len,
                                               input logic             mdfy);
        if (mdfy || (len == '0)) return LEN_W'(1);
        return len;
    endfunction

    assign in_burst  = (state_q != IDLE);
    assign last_beat = (cnt_q == LEN_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // last_q = 1 means PM was granted last, so DM wins the next tie
    always_comb begin
        state_d  = state_q;
        grant_dm = 1'b0;
        grant_pm = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.dm_req && (!bus.pm_req || !RR_EN || last_q)) begin
                    grant_dm = 1'b1;
                    state_d  = DM_BURST;
                end else if (bus.pm_req) begin
                    grant_pm = 1'b1;
                    state_d  = PM_BURST;
                end
            end
            DM_BURST, PM_BURST: begin
                if (bus.abort || last_beat) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // cnt holds the beats remaining including the one currently on the bus
    always_comb begin
        cnt_d     = cnt_q;
        iadd_d    = iadd_q;
        madd_d    = madd_q;
        mdfy_d    = mdfy_q;
        sel_d     = sel_q;
        last_d    = last_q;
        dm_gnt_d  = 1'b0;
        pm_gnt_d  = 1'b0;
        dm_done_d = 1'b0;
        pm_done_d = 1'b0;
        if (grant_dm) begin
            iadd_d    = bus.dm_iadd;
            madd_d    = bus.dm_madd;
            mdfy_d    = bus.dm_mdfy;
            sel_d     = 1'b0;
            last_d    = 1'b0;
            cnt_d     = beats(bus.dm_len, bus.dm_mdfy);
            dm_gnt_d  = 1'b1;
            dm_done_d = (cnt_d == LEN_W'(1));
        end else if (grant_pm) begin
            iadd_d    = bus.pm_iadd;
            madd_d    = bus.pm_madd;
            mdfy_d    = bus.pm_mdfy;
            sel_d     = 1'b1;
            last_d    = 1'b1;
            cnt_d     = beats(bus.pm_len, bus.pm_mdfy);
            pm_gnt_d  = 1'b1;
            pm_done_d = (cnt_d == LEN_W'(1));
        end else if (in_burst) begin
            if (bus.abort || last_beat) begin
                cnt_d = '0;
            end else begin
                cnt_d     = cnt_q - LEN_W'(1);
                dm_done_d = (state_q == DM_BURST) && (cnt_q == LEN_W'(2));
                pm_done_d = (state_q == PM_BURST) && (cnt_q == LEN_W'(2));
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            iadd_q    <= '0;
            madd_q    <= '0;
            mdfy_q    <= 1'b0;
            sel_q     <= 1'b0;
            last_q    <= 1'b1;
            dm_gnt_q  <= 1'b0;
            pm_gnt_q  <= 1'b0;
            dm_done_q <= 1'b0;
            pm_done_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            iadd_q    <= iadd_d;
            madd_q    <= madd_d;
            mdfy_q    <= mdfy_d;
            sel_q     <= sel_d;
            last_q    <= last_d;
            dm_gnt_q  <= dm_gnt_d;
            pm_gnt_q  <= pm_gnt_d;
            dm_done_q <= dm_done_d;
            pm_done_q <= pm_done_d;
        end
    end

    // A write may not touch the I or M register the running burst is using
    assign conflict = in_burst &&
                      ((bus.wr_add == {1'b1, sel_q, iadd_q}) ||
                       (bus.wr_add == {1'b0, sel_q, madd_q}));

    assign bus.wr_rdy        = ~conflict;
    assign bus.ps_dg_wrt_en  = bus.wr_req & ~conflict;
    assign bus.ps_dg_wrt_add = bus.wr_add;

    assign bus.ps_dg_en     = in_burst;
    assign bus.busy         = in_burst;
    assign bus.ps_dg_dgsclt = sel_q;
    assign bus.ps_dg_mdfy   = mdfy_q;
    assign bus.ps_dg_iadd   = iadd_q;
    assign bus.ps_dg_madd   = madd_q;
    assign bus.dm_gnt       = dm_gnt_q;
    assign bus.pm_gnt       = pm_gnt_q;
    assign bus.dm_done      = dm_done_q;
    assign bus.pm_done      = pm_done_q;
endmodule

// File: tb/tb_dag_seq.sv
// Directed bench for dag_seq: arbitration order, burst timing, abort, write stalls, reset.
module tb_dag_seq;
    localparam int unsigned LEN_W = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_run  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    dag_seq_if #(.LEN_W(LEN_W)) bus ();

    dag_seq #(.LEN_W(LEN_W), .RR_EN(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.dm_req = 1'b0; bus.dm_iadd = '0; bus.dm_madd = '0; bus.dm_mdfy = 1'b0; bus.dm_len = '0;
        bus.pm_req = 1'b0; bus.pm_iadd = '0; bus.pm_madd = '0; bus.pm_mdfy = 1'b0; bus.pm_len = '0;
        bus.wr_req = 1'b0; bus.wr_add = '0; bus.abort = 1'b0;
    endtask

    task automatic req_dm(input logic [2:0] i, input logic [2:0] m, input logic md,
                          input logic [LEN_W-1:0] len);
        bus.dm_iadd = i; bus.dm_madd = m; bus.dm_mdfy = md; bus.dm_len = len; bus.dm_req = 1'b1;
    endtask

    task automatic req_pm(input logic [2:0] i, input logic [2:0] m, input logic md,
                          input logic [LEN_W-1:0] len);
        bus.pm_iadd = i; bus.pm_madd = m; bus.pm_mdfy = md; bus.pm_len = len; bus.pm_req = 1'b1;
    endtask

    // Per-cycle expectations for held DM+PM single-beat requests
    int e_en  [7] = '{1, 0, 1, 0, 1, 0, 1};
    int e_sel [7] = '{0, 0, 1, 1, 0, 0, 1};
    int e_dg  [7] = '{1, 0, 0, 0, 1, 0, 0};
    int e_pg  [7] = '{0, 0, 1, 0, 0, 0, 1};
    int e_ia  [7] = '{1, 1, 5, 5, 1, 1, 5};

    initial begin
        int beats_seen;
        int dones_seen;
        int guard;

        clear_inputs();
        #12;
        chk("rst_en",     32'(bus.ps_dg_en), 1'b0);
        chk("rst_busy",   32'(bus.busy), 1'b0);
        chk("rst_dm_gnt", 32'(bus.dm_gnt), 1'b0);
        chk("rst_pm_gnt", 32'(bus.pm_gnt), 1'b0);
        chk("rst_done",   32'({bus.dm_done, bus.pm_done}), 0);
        chk("rst_iadd",   32'(bus.ps_dg_iadd), 0);
        chk("rst_wr_rdy", 32'(bus.wr_rdy), 1);
        rst_n = 1'b1;
        tick();

        // Round-robin between continuously held DM and PM requests
        req_dm(3'd1, 3'd0, 1'b0, 8'd1);
        req_pm(3'd5, 3'd0, 1'b0, 8'd1);
        for (int c = 0; c < 7; c++) begin
            tick();
            chk($sformatf("rr_en[%0d]", c),   32'(bus.ps_dg_en), 32'(e_en[c]));
            chk($sformatf("rr_sel[%0d]", c),  32'(bus.ps_dg_dgsclt), 32'(e_sel[c]));
            chk($sformatf("rr_dgnt[%0d]", c), 32'(bus.dm_gnt), 32'(e_dg[c]));
            chk($sformatf("rr_pgnt[%0d]", c), 32'(bus.pm_gnt), 32'(e_pg[c]));
            chk($sformatf("rr_iadd[%0d]", c), 32'(bus.ps_dg_iadd), 32'(e_ia[c]));
        end
        bus.dm_req = 1'b0;
        bus.pm_req = 1'b0;
        tick();
        chk("rr_end_busy", 32'(bus.busy), 0);

        // Single DM post-modify burst of 3
        req_dm(3'd2, 3'd1, 1'b0, 8'd3);
        tick();
        chk("dm_b1_gnt",  32'(bus.dm_gnt), 1);
        chk("dm_b1_en",   32'(bus.ps_dg_en), 1);
        chk("dm_b1_sel",  32'(bus.ps_dg_dgsclt), 0);
        chk("dm_b1_iadd", 32'(bus.ps_dg_iadd), 2);
        chk("dm_b1_madd", 32'(bus.ps_dg_madd), 1);
        chk("dm_b1_mdfy", 32'(bus.ps_dg_mdfy), 0);
        chk("dm_b1_done", 32'(bus.dm_done), 0);
        bus.dm_req = 1'b0;
        tick();
        chk("dm_b2_en",   32'(bus.ps_dg_en), 1);
        chk("dm_b2_gnt",  32'(bus.dm_gnt), 0);
        chk("dm_b2_done", 32'(bus.dm_done), 0);
        tick();
        chk("dm_b3_en",   32'(bus.ps_dg_en), 1);
        chk("dm_b3_done", 32'(bus.dm_done), 1);
        tick();
        chk("dm_end_en",   32'(bus.ps_dg_en), 0);
        chk("dm_end_busy", 32'(bus.busy), 0);
        chk("dm_end_done", 32'(bus.dm_done), 0);

        // Pre-modify collapses len=5 to one beat
        req_pm(3'd6, 3'd3, 1'b1, 8'd5);
        tick();
        chk("pre_gnt",  32'(bus.pm_gnt), 1);
        chk("pre_en",   32'(bus.ps_dg_en), 1);
        chk("pre_sel",  32'(bus.ps_dg_dgsclt), 1);
        chk("pre_mdfy", 32'(bus.ps_dg_mdfy), 1);
        chk("pre_iadd", 32'(bus.ps_dg_iadd), 6);
        chk("pre_madd", 32'(bus.ps_dg_madd), 3);
        chk("pre_done", 32'(bus.pm_done), 1);
        bus.pm_req = 1'b0;
        tick();
        chk("pre_end_en",   32'(bus.ps_dg_en), 0);
        chk("pre_end_done", 32'(bus.pm_done), 0);

        // Write gating during a DM burst with I4/M1
        req_dm(3'd4, 3'd1, 1'b0, 8'd4);
        tick();
        bus.dm_req = 1'b0;
        bus.wr_req = 1'b1;
        bus.wr_add = 5'b10100;
        #1;
        chk("wr_b1_rdy", 32'(bus.wr_rdy), 0);
        chk("wr_b1_en",  32'(bus.ps_dg_wrt_en), 0);
        tick();
        bus.wr_add = 5'b11000;
        #1;
        chk("wr_b2_rdy", 32'(bus.wr_rdy), 1);
        chk("wr_b2_en",  32'(bus.ps_dg_wrt_en), 1);
        chk("wr_b2_add", 32'(bus.ps_dg_wrt_add), 32'h18);
        tick();
        bus.wr_add = 5'b00001;
        #1;
        chk("wr_b3_mconf", 32'(bus.wr_rdy), 0);
        tick();
        bus.wr_add = 5'b10100;
        #1;
        chk("wr_b4_rdy",  32'(bus.wr_rdy), 0);
        chk("wr_b4_den",  32'(bus.ps_dg_en), 1);
        chk("wr_b4_done", 32'(bus.dm_done), 1);
        tick();
        chk("wr_rel_rdy", 32'(bus.wr_rdy), 1);
        chk("wr_rel_en",  32'(bus.ps_dg_wrt_en), 1);
        chk("wr_rel_add", 32'(bus.ps_dg_wrt_add), 32'h14);
        chk("wr_rel_den", 32'(bus.ps_dg_en), 0);
        bus.wr_req = 1'b0;

        // Abort on beat 2 of a len=6 burst
        req_dm(3'd0, 3'd0, 1'b0, 8'd6);
        tick();
        chk("ab_b1_en", 32'(bus.ps_dg_en), 1);
        bus.dm_req = 1'b0;
        tick();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("ab_en",   32'(bus.ps_dg_en), 0);
        chk("ab_busy", 32'(bus.busy), 0);
        dones_seen = int'(bus.dm_done);
        for (int c = 0; c < 6; c++) begin
            tick();
            dones_seen += int'(bus.dm_done);
        end
        chk("ab_no_done", 32'(dones_seen), 0);

        // Abort coincident with a grant: grant completes, burst dies next cycle
        req_dm(3'd7, 3'd2, 1'b0, 8'd3);
        bus.abort = 1'b1;
        tick();
        chk("abg_gnt",  32'(bus.dm_gnt), 1);
        chk("abg_en",   32'(bus.ps_dg_en), 1);
        chk("abg_iadd", 32'(bus.ps_dg_iadd), 7);
        bus.dm_req = 1'b0;
        tick();
        bus.abort = 1'b0;
        chk("abg_en2",  32'(bus.ps_dg_en), 0);
        chk("abg_done", 32'(bus.dm_done), 0);
        tick();

        // len=0 behaves as a single beat
        req_dm(3'd3, 3'd3, 1'b0, 8'd0);
        tick();
        chk("len0_en",   32'(bus.ps_dg_en), 1);
        chk("len0_done", 32'(bus.dm_done), 1);
        bus.dm_req = 1'b0;
        tick();
        chk("len0_end", 32'(bus.ps_dg_en), 0);

        // Maximum length: 255 beats, one done
        req_dm(3'd1, 3'd1, 1'b0, 8'd255);
        tick();
        bus.dm_req = 1'b0;
        beats_seen = 0;
        dones_seen = 0;
        guard      = 0;
        while (bus.ps_dg_en && guard < 300) begin
            beats_seen++;
            dones_seen += int'(bus.dm_done);
            tick();
            guard++;
        end
        chk("max_beats", 32'(beats_seen), 255);
        chk("max_dones", 32'(dones_seen), 1);
        tick();

        // Reset during beat 3, then the first tie goes to DM
        req_dm(3'd2, 3'd2, 1'b0, 8'd5);
        tick();
        bus.dm_req = 1'b0;
        tick();
        tick();
        chk("mr_b3_en", 32'(bus.ps_dg_en), 1);
        rst_n = 1'b0;
        #1;
        chk("mr_en",   32'(bus.ps_dg_en), 0);
        chk("mr_busy", 32'(bus.busy), 0);
        chk("mr_iadd", 32'(bus.ps_dg_iadd), 0);
        chk("mr_done", 32'(bus.dm_done), 0);
        req_dm(3'd4, 3'd0, 1'b0, 8'd1);
        req_pm(3'd6, 3'd0, 1'b0, 8'd1);
        #2;
        rst_n = 1'b1;
        tick();
        chk("mr_tie_dgnt", 32'(bus.dm_gnt), 1);
        chk("mr_tie_pgnt", 32'(bus.pm_gnt), 0);
        chk("mr_tie_sel",  32'(bus.ps_dg_dgsclt), 0);
        clear_inputs();
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
